// File: rtl/board_mem_ctrl.sv
// Board memory responder for the connect-four display.
// Holds the 6x7 board (2-bit cells: 0 empty, 1 player1, 2 player2), answers row reads
// from the VGA renderer and executes gravity drops from the game FSM.
// Optional feature macro: BOARD_MC_MOVE_COUNT_EN adds move_cnt/board_full outputs and
// rejects drops without scanning once the board is full.
module board_mem_ctrl #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ROW_STRIDE   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rden,
    input  logic [5:0]  addr,
    output logic        ready,
    output logic [13:0] data,
    input  logic        drop_req,
    input  logic [2:0]  drop_col,
    input  logic [1:0]  drop_player,
    output logic        drop_ack,
    output logic        drop_ok,
    input  logic        clear_board
`ifdef BOARD_MC_MOVE_COUNT_EN
    ,
    output logic [5:0]  move_cnt,
    output logic        board_full
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdAck,
        StRdHold,
        StDropScan,
        StDropDone
    } state_e;

    state_e     state_q;
    logic [1:0] board_q [6][7];
    logic [5:0] addr_q;
    logic [2:0] lat_cnt_q;
    logic [2:0] scan_row_q;
    logic [2:0] col_q;
    logic [1:0] player_q;

    logic [5:0]  rd_addr;
    logic        rd_hit;
    logic [2:0]  rd_row;
    logic [13:0] rd_word;
    logic [1:0]  scan_cell;
    logic        drop_legal;
    logic        drops_blocked;

    // Row decode: in IDLE the live address is used so a latency-1 read needs no wait state
    always_comb begin
        rd_addr = (state_q == StIdle) ? addr : addr_q;
        rd_hit  = 1'b0;
        rd_row  = 3'd0;
        rd_word = 14'd0;
        for (int r = 0; r < 6; r++) begin
            if ({26'd0, rd_addr} == 32'(r) * ROW_STRIDE) begin
                rd_hit = 1'b1;
                rd_row = 3'(r);
            end
        end
        if (rd_hit) begin
            for (int c = 0; c < 7; c++) begin
                rd_word[2*c +: 2] = board_q[rd_row][c];
            end
        end
    end

    // Drop request qualification and the cell currently under the scan pointer
    always_comb begin
        scan_cell  = board_q[scan_row_q][col_q];
        drop_legal = (drop_col <= 3'd6) && ((drop_player == 2'd1) || (drop_player == 2'd2));
    end

`ifdef BOARD_MC_MOVE_COUNT_EN
    logic [5:0] move_cnt_q;
    logic       place_en;
    logic       clear_en;

    assign place_en      = (state_q == StDropScan) && (scan_cell == 2'd0);
    assign clear_en      = (state_q == StIdle) && clear_board;
    assign move_cnt      = move_cnt_q;
    assign board_full    = (move_cnt_q == 6'd42);
    assign drops_blocked = board_full;

    // Successful-drop counter, saturating at a full board
    always_ff @(posedge clk) begin
        if (!rst) begin
            move_cnt_q <= 6'd0;
        end else if (clear_en) begin
            move_cnt_q <= 6'd0;
        end else if (place_en && (move_cnt_q != 6'd42)) begin
            move_cnt_q <= move_cnt_q + 6'd1;
        end
    end
`else
    assign drops_blocked = 1'b0;
`endif

    // Main controller: FSM, board storage and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ready      <= 1'b0;
            data       <= 14'd0;
            drop_ack   <= 1'b0;
            drop_ok    <= 1'b0;
            addr_q     <= 6'd0;
            lat_cnt_q  <= 3'd0;
            scan_row_q <= 3'd0;
            col_q      <= 3'd0;
            player_q   <= 2'd0;
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 7; c++) begin
                    board_q[r][c] <= 2'd0;
                end
            end
        end else begin
            ready    <= 1'b0;
            drop_ack <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_board) begin
                        for (int r = 0; r < 6; r++) begin
                            for (int c = 0; c < 7; c++) begin
                                board_q[r][c] <= 2'd0;
                            end
                        end
                    end else if (rden) begin
                        addr_q <= addr;
                        if (READ_LATENCY <= 1) begin
                            ready   <= 1'b1;
                            data    <= rd_word;
                            state_q <= StRdAck;
                        end else begin
                            lat_cnt_q <= 3'd1;
                            state_q   <= StRdWait;
                        end
                    end else if (drop_req) begin
                        col_q      <= drop_col;
                        player_q   <= drop_player;
                        scan_row_q <= 3'd5;
                        if (!drop_legal || drops_blocked) begin
                            drop_ok  <= 1'b0;
                            drop_ack <= 1'b1;
                            state_q  <= StDropDone;
                        end else begin
                            state_q <= StDropScan;
                        end
                    end
                end
                StRdWait: begin
                    if (lat_cnt_q >= 3'(READ_LATENCY - 1)) begin
                        ready   <= 1'b1;
                        data    <= rd_word;
                        state_q <= StRdAck;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                StRdAck: begin
                    state_q <= StRdHold;
                end
                StRdHold: begin
                    // One ready per request: wait for the renderer to let go of rden
                    if (!rden) begin
                        state_q <= StIdle;
                    end
                end
                StDropScan: begin
                    if (scan_cell == 2'd0) begin
                        board_q[scan_row_q][col_q] <= player_q;
                        drop_ok  <= 1'b1;
                        drop_ack <= 1'b1;
                        state_q  <= StDropDone;
                    end else if (scan_row_q == 3'd0) begin
                        drop_ok  <= 1'b0;
                        drop_ack <= 1'b1;
                        state_q  <= StDropDone;
                    end else begin
                        scan_row_q <= scan_row_q - 3'd1;
                    end
                end
                StDropDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
